// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-ported, byte-addressed
// memory with a combinational read path.
//
// Requester 0 is the CPU data port and requester 1 is the loader/debug port.
// Grants are combinational. Each accepted request is captured on the grant edge
// and driven to memory for exactly one ACCESS cycle. The response, either load
// data, a store acknowledge or an error, is presented to the owner one cycle
// after that. Fixed latency: grant N, memory N+1, rvalid N+2.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rX_req_i / rX_lock_i       request, and a request to hold the grant
//   rX_addr_i / rX_mode_i      byte address and AddrMode (LB..SW)
//   rX_wdata_i                 store data
//   rX_gnt_o                   request accepted this cycle (combinational)
//   rX_rvalid_o / rX_rdata_o   one-cycle response and its load data
//   rX_err_o                   response belongs to a rejected access
//   mem_addr_o/mem_mode_o/mem_wd_o  captured access; idles as LW of address 0
//   mem_rd_i                   combinational read data from memory
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ADDR_REAL_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  r0_req_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [2:0]            r0_mode_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  input  logic                  r0_lock_i,
  output logic                  r0_gnt_o,
  output logic                  r0_rvalid_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  output logic                  r0_err_o,

  input  logic                  r1_req_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [2:0]            r1_mode_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  input  logic                  r1_lock_i,
  output logic                  r1_gnt_o,
  output logic                  r1_rvalid_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  r1_err_o,

  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [2:0]            mem_mode_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  localparam logic [2:0] MODE_LB  = 3'b000;
  localparam logic [2:0] MODE_LH  = 3'b001;
  localparam logic [2:0] MODE_LW  = 3'b010;
  localparam logic [2:0] MODE_LBU = 3'b011;
  localparam logic [2:0] MODE_LHU = 3'b100;
  localparam logic [2:0] MODE_SB  = 3'b101;
  localparam logic [2:0] MODE_SH  = 3'b110;
  localparam logic [2:0] MODE_SW  = 3'b111;

  localparam int unsigned END_W = ADDR_WIDTH + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Arbitration state: last granted requester and whether it holds a lock.
  // last_q resets to 1 so that requester 0 has round-robin priority.
  logic last_q, last_d;
  logic lock_q, lock_d;

  // Captured access, driven straight to memory during ACCESS
  logic                  acc_owner_q, acc_owner_d;
  logic                  acc_err_q, acc_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]            mem_mode_q, mem_mode_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;

  // Per-requester response registers
  logic                  r0_rvalid_q, r0_rvalid_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
  logic                  r0_err_q, r0_err_d;
  logic                  r1_rvalid_q, r1_rvalid_d;
  logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
  logic                  r1_err_q, r1_err_d;

  // Arbitration result and the selected request fields
  logic                  lock_hit;
  logic                  gnt_any;
  logic                  gnt_sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_mode;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_lock;

  // Request checking
  logic [1:0]            size_m1;
  logic                  misalign;
  logic [END_W-1:0]      end_addr;
  logic                  out_of_range;
  logic                  sel_reject;

  logic                  acc_is_store;
  logic [DATA_WIDTH-1:0] rsp_data;

  // A held lock persists only while its owner keeps both req and lock high
  assign lock_hit = lock_q && (last_q ? (r1_req_i && r1_lock_i)
                                      : (r0_req_i && r0_lock_i));

  // Grant selection: lock owner first, otherwise round-robin on contention.
  // No grant can be issued while reset is asserted.
  always_comb begin : arbitrate
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (rst_n) begin
      if (lock_hit) begin
        gnt_any = 1'b1;
        gnt_sel = last_q;
      end else if (r0_req_i && r1_req_i) begin
        gnt_any = 1'b1;
        gnt_sel = ~last_q;
      end else if (r0_req_i) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end else if (r1_req_i) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
    end
  end

  assign r0_gnt_o = gnt_any && !gnt_sel;
  assign r1_gnt_o = gnt_any &&  gnt_sel;

  assign sel_addr  = gnt_sel ? r1_addr_i  : r0_addr_i;
  assign sel_mode  = gnt_sel ? r1_mode_i  : r0_mode_i;
  assign sel_wdata = gnt_sel ? r1_wdata_i : r0_wdata_i;
  assign sel_lock  = gnt_sel ? r1_lock_i  : r0_lock_i;

  // Alignment and range check of the selected request
  always_comb begin : check_access
    size_m1  = 2'd0;
    misalign = 1'b0;
    case (sel_mode)
      MODE_LH, MODE_LHU, MODE_SH: begin
        size_m1  = 2'd1;
        misalign = sel_addr[0];
      end
      MODE_LW, MODE_SW: begin
        size_m1  = 2'd3;
        misalign = |sel_addr[1:0];
      end
      default: begin
        size_m1  = 2'd0;
        misalign = 1'b0;
      end
    endcase
    // The last byte touched lies at or above the start address, so a single
    // test on it covers both the start and the end of the access.
    end_addr     = {1'b0, sel_addr} + END_W'(size_m1);
    out_of_range = |end_addr[END_W-1:ADDR_REAL_WIDTH];
    sel_reject   = misalign || out_of_range;
  end

  // Rejected accesses are captured as LW of 0, so only accepted stores remain
  assign acc_is_store = (mem_mode_q == MODE_SB) || (mem_mode_q == MODE_SH) ||
                        (mem_mode_q == MODE_SW);

  // Next-state, capture and response logic
  always_comb begin : next_state
    state_d     = ST_IDLE;
    last_d      = last_q;
    lock_d      = 1'b0;
    acc_owner_d = acc_owner_q;
    acc_err_d   = 1'b0;
    mem_addr_d  = '0;
    mem_mode_d  = MODE_LW;
    mem_wd_d    = '0;
    r0_rvalid_d = 1'b0;
    r0_rdata_d  = '0;
    r0_err_d    = 1'b0;
    r1_rvalid_d = 1'b0;
    r1_rdata_d  = '0;
    r1_err_d    = 1'b0;
    rsp_data    = '0;

    // A grant starts an ACCESS in either state
    if (gnt_any) begin
      state_d     = ST_ACCESS;
      last_d      = gnt_sel;
      lock_d      = sel_lock;
      acc_owner_d = gnt_sel;
      acc_err_d   = sel_reject;
      if (!sel_reject) begin
        mem_addr_d = sel_addr;
        mem_mode_d = sel_mode;
        mem_wd_d   = sel_wdata;
      end
    end

    // The edge ending ACCESS turns the access into its owner's response
    if (state_q == ST_ACCESS) begin
      rsp_data = (acc_err_q || acc_is_store) ? '0 : mem_rd_i;
      if (acc_owner_q) begin
        r1_rvalid_d = 1'b1;
        r1_rdata_d  = rsp_data;
        r1_err_d    = acc_err_q;
      end else begin
        r0_rvalid_d = 1'b1;
        r0_rdata_d  = rsp_data;
        r0_err_d    = acc_err_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset immediately parks the memory port on a load
  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      acc_owner_q <= 1'b0;
      acc_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_mode_q  <= MODE_LW;
      mem_wd_q    <= '0;
      r0_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r0_err_q    <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r1_rdata_q  <= '0;
      r1_err_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_q      <= lock_d;
      acc_owner_q <= acc_owner_d;
      acc_err_q   <= acc_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_mode_q  <= mem_mode_d;
      mem_wd_q    <= mem_wd_d;
      r0_rvalid_q <= r0_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r0_err_q    <= r0_err_d;
      r1_rvalid_q <= r1_rvalid_d;
      r1_rdata_q  <= r1_rdata_d;
      r1_err_q    <= r1_err_d;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_mode_o  = mem_mode_q;
  assign mem_wd_o    = mem_wd_q;

  assign r0_rvalid_o = r0_rvalid_q;
  assign r0_rdata_o  = r0_rdata_q;
  assign r0_err_o    = r0_err_q;
  assign r1_rvalid_o = r1_rvalid_q;
  assign r1_rdata_o  = r1_rdata_q;
  assign r1_err_o    = r1_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table of single-requester accesses plus hand sequences for
// contention, lock and reset during ACCESS. Expected responses are queued at
// grant and matched against the rvalid outputs by a scoreboard monitor.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100;
  localparam logic [2:0] SB  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SW  = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_lock, r0_gnt, r0_rvalid, r0_err;
  logic [AW-1:0] r0_addr;
  logic [2:0]    r0_mode;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_lock, r1_gnt, r1_rvalid, r1_err;
  logic [AW-1:0] r1_addr;
  logic [2:0]    r1_mode;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_mode;
  logic [DW-1:0] mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_REAL_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_mode_i(r0_mode),
    .r0_wdata_i(r0_wdata), .r0_lock_i(r0_lock), .r0_gnt_o(r0_gnt),
    .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata), .r0_err_o(r0_err),
    .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_mode_i(r1_mode),
    .r1_wdata_i(r1_wdata), .r1_lock_i(r1_lock), .r1_gnt_o(r1_gnt),
    .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata), .r1_err_o(r1_err),
    .mem_addr_o(mem_addr), .mem_mode_o(mem_mode), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd)
  );

  // Byte-addressed little-endian memory model, 4 KiB aliased window
  logic [7:0]  bmem [0:4095];
  logic [11:0] b0, b1, b2, b3;
  assign b0 = mem_addr[11:0];
  assign b1 = b0 + 12'd1;
  assign b2 = b0 + 12'd2;
  assign b3 = b0 + 12'd3;

  always_comb begin
    mem_rd = '0;
    case (mem_mode)
      LB:  mem_rd = {{24{bmem[b0][7]}}, bmem[b0]};
      LBU: mem_rd = {24'h0, bmem[b0]};
      LH:  mem_rd = {{16{bmem[b1][7]}}, bmem[b1], bmem[b0]};
      LHU: mem_rd = {16'h0, bmem[b1], bmem[b0]};
      LW:  mem_rd = {bmem[b3], bmem[b2], bmem[b1], bmem[b0]};
      default: mem_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    case (mem_mode)
      SB: bmem[b0] <= mem_wd[7:0];
      SH: begin
        bmem[b0] <= mem_wd[7:0];
        bmem[b1] <= mem_wd[15:8];
      end
      SW: begin
        bmem[b0] <= mem_wd[7:0];
        bmem[b1] <= mem_wd[15:8];
        bmem[b2] <= mem_wd[23:16];
        bmem[b3] <= mem_wd[31:24];
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] bword(input int a);
    return {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic push(input logic id, input logic [31:0] rd, input logic er, input string tag);
    exp_t e;
    e.id = id; e.rdata = rd; e.err = er; e.due = cyc + 2; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic add(input logic [31:0] a, input logic [2:0] m, input logic [31:0] wd,
                     input logic [31:0] rd, input logic er);
    vec_t v;
    v.addr = a; v.mode = m; v.wdata = wd; v.exp_rdata = rd; v.exp_err = er;
    vt.push_back(v);
  endtask

  task automatic idle_all();
    r0_req = 1'b0; r0_lock = 1'b0; r0_addr = '0; r0_mode = LW; r0_wdata = '0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_addr = '0; r1_mode = LW; r1_wdata = '0;
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [2:0] m,
                       input logic [31:0] wd, input logic lk);
    if (!id) begin
      r0_req = 1'b1; r0_addr = a; r0_mode = m; r0_wdata = wd; r0_lock = lk;
    end else begin
      r1_req = 1'b1; r1_addr = a; r1_mode = m; r1_wdata = wd; r1_lock = lk;
    end
  endtask

  // Requester 0 alone: wait (bounded) for its grant and queue the response
  task automatic issue(input string tag, input logic [31:0] a, input logic [2:0] m,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er);
    bit got = 1'b0;
    drive(1'b0, a, m, wd, 1'b0);
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (r0_gnt) begin
        got = 1'b1;
        push(1'b0, rd, er, tag);
        chk({tag, " r1_gnt"}, 32'(r1_gnt), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk({tag, " r0_gnt"}, 32'(got), 32'd1);
  endtask

  // One cycle of a hand sequence: check both grants, queue the winner
  task automatic step(input string nm, input logic eg0, input logic eg1,
                      input logic [31:0] x0, input logic e0,
                      input logic [31:0] x1, input logic e1);
    @(negedge clk);
    chk({nm, " r0_gnt"}, 32'(r0_gnt), 32'(eg0));
    chk({nm, " r1_gnt"}, 32'(r1_gnt), 32'(eg1));
    if (r0_gnt) push(1'b0, x0, e0, nm);
    if (r1_gnt) push(1'b1, x1, e1, nm);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " r0_gnt"},    32'(r0_gnt),    32'd0);
    chk({nm, " r1_gnt"},    32'(r1_gnt),    32'd0);
    chk({nm, " r0_rvalid"}, 32'(r0_rvalid), 32'd0);
    chk({nm, " r1_rvalid"}, 32'(r1_rvalid), 32'd0);
    chk({nm, " r0_rdata"},  r0_rdata,       32'd0);
    chk({nm, " r1_rdata"},  r1_rdata,       32'd0);
    chk({nm, " r0_err"},    32'(r0_err),    32'd0);
    chk({nm, " r1_err"},    32'(r1_err),    32'd0);
    chk({nm, " mem_mode"},  32'(mem_mode),  32'(LW));
    chk({nm, " mem_addr"},  mem_addr,       32'd0);
    chk({nm, " mem_wd"},    mem_wd,         32'd0);
  endtask

  // Scoreboard: every response must match the head of the queue in owner,
  // cycle, data and error flag
  task automatic monitor();
    exp_t e;
    logic id;
    forever begin
      @(negedge clk);
      if (r0_rvalid && r1_rvalid) begin
        fail("both rvalid high");
      end else if (r0_rvalid || r1_rvalid) begin
        id = r1_rvalid;
        if (sb.size() == 0) begin
          fail($sformatf("unexpected rvalid on r%0d", id));
        end else begin
          e = sb.pop_front();
          chk({e.tag, " rsp owner"},   32'(id), 32'(e.id));
          chk({e.tag, " rsp latency"}, 32'(cyc), 32'(e.due));
          chk({e.tag, " rsp rdata"},   id ? r1_rdata : r0_rdata, e.rdata);
          chk({e.tag, " rsp err"},     32'(id ? r1_err : r0_err), 32'(e.err));
          chk({e.tag, " other rdata"}, id ? r0_rdata : r1_rdata, 32'd0);
          chk({e.tag, " other err"},   32'(id ? r0_err : r1_err), 32'd0);
        end
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        fail({sb[0].tag, " response missing"});
        void'(sb.pop_front());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addr, mode, wdata, expected rdata, expected err
    add(32'h0000_0000, SW,  32'h5555_AAAA, 32'h0000_0000, 1'b0);
    add(32'h0000_0100, SB,  32'h0000_0080, 32'h0000_0000, 1'b0);
    add(32'h0000_0104, SW,  32'h8081_7F42, 32'h0000_0000, 1'b0);
    add(32'h0000_0040, SW,  32'h0102_0304, 32'h0000_0000, 1'b0);
    add(32'h0000_0100, LB,  32'h0,         32'hFFFF_FF80, 1'b0);
    add(32'h0000_0100, LBU, 32'h0,         32'h0000_0080, 1'b0);
    add(32'h0000_0104, LW,  32'h0,         32'h8081_7F42, 1'b0);
    add(32'h0000_0106, LH,  32'h0,         32'hFFFF_8081, 1'b0);
    add(32'h0000_0104, LHU, 32'h0,         32'h0000_7F42, 1'b0);
    add(32'h0000_0105, LB,  32'h0,         32'h0000_007F, 1'b0);
    add(32'h0000_0102, LW,  32'h0,         32'h0000_0000, 1'b1);
    add(32'h0010_0000, SB,  32'h0000_00FF, 32'h0000_0000, 1'b1);
    add(32'h0000_0101, LH,  32'h0,         32'h0000_0000, 1'b1);
    add(32'h0000_0100, LBU, 32'h0,         32'h0000_0080, 1'b0);
    add(32'h000F_FFFC, SW,  32'h1122_3344, 32'h0000_0000, 1'b0);
    add(32'h000F_FFFC, LW,  32'h0,         32'h1122_3344, 1'b0);
    add(32'h000F_FFFE, LHU, 32'h0,         32'h0000_1122, 1'b0);
    add(32'h000F_FFFF, LBU, 32'h0,         32'h0000_0011, 1'b0);
    add(32'h000F_FFFE, LW,  32'h0,         32'h0000_0000, 1'b1);
    add(32'h0010_0000, LHU, 32'h0,         32'h0000_0000, 1'b1);
    add(32'h8000_0000, LW,  32'h0,         32'h0000_0000, 1'b1);
    add(32'h0000_0010, SH,  32'h1234_BEEF, 32'h0000_0000, 1'b0);
    add(32'h0000_0010, LHU, 32'h0,         32'h0000_BEEF, 1'b0);
    add(32'h0000_0010, LH,  32'h0,         32'hFFFF_BEEF, 1'b0);
    add(32'h0000_0000, LW,  32'h0,         32'h5555_AAAA, 1'b0);

    for (int k = 0; k < vt.size(); k++)
      issue($sformatf("v%0d", k), vt[k].addr, vt[k].mode, vt[k].wdata,
            vt[k].exp_rdata, vt[k].exp_err);
    idle_all();
    repeat (4) @(posedge clk);
    #1;
    chk("drain table", 32'(sb.size()), 32'd0);

    // Reset while a store is in ACCESS: the store must never commit
    drive(1'b0, 32'h40, SW, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("rst store gnt", 32'(r0_gnt), 32'd1);
    @(posedge clk); #1;
    idle_all();
    chk("rst access mode", 32'(mem_mode), 32'(SW));
    chk("rst access addr", mem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async mode", 32'(mem_mode), 32'(LW));
    chk("rst async wd", mem_wd, 32'd0);
    drive(1'b0, 32'h104, LW, 32'h0, 1'b0);
    #1;
    check_reset_outputs("in reset");
    @(posedge clk); #1;
    check_reset_outputs("in reset edge");
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk("mem 0x40 kept", bword(32'h40), 32'h0102_0304);
    @(posedge clk); #1;

    // Contention after reset: requester 0 first, then strict alternation
    drive(1'b0, 32'h104, LW,  32'h0, 1'b0);
    drive(1'b1, 32'h100, LBU, 32'h0, 1'b0);
    step("cont0", 1'b1, 1'b0, 32'h8081_7F42, 1'b0, 32'h80, 1'b0);
    step("cont1", 1'b0, 1'b1, 32'h8081_7F42, 1'b0, 32'h80, 1'b0);
    step("cont2", 1'b1, 1'b0, 32'h8081_7F42, 1'b0, 32'h80, 1'b0);
    step("cont3", 1'b0, 1'b1, 32'h8081_7F42, 1'b0, 32'h80, 1'b0);

    // Lock: r1 keeps the grant for three stores while r0 waits
    idle_all();
    drive(1'b1, 32'h200, SW, 32'hCAFE_0001, 1'b1);
    step("lock0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h100, LBU, 32'h0, 1'b0);
    drive(1'b1, 32'h200, SW, 32'hCAFE_0002, 1'b1);
    step("lock1", 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h200, SW, 32'hCAFE_0003, 1'b1);
    step("lock2", 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    r1_req = 1'b0; r1_lock = 1'b0;
    step("lock3", 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
    idle_all();

    issue("rb200", 32'h200, LW, 32'h0, 32'hCAFE_0003, 1'b0);
    issue("rb040", 32'h040, LW, 32'h0, 32'h0102_0304, 1'b0);
    idle_all();
    repeat (4) @(posedge clk);
    #1;
    chk("drain final", 32'(sb.size()), 32'd0);
    chk("mem 0x000", bword(32'h000), 32'h5555_AAAA);
    chk("mem 0x100", 32'(bmem[12'h100]), 32'h80);
    chk("mem 0x010", 32'({bmem[12'h011], bmem[12'h010]}), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters: DATA_WIDTH, 32, data width; ADDR_WIDTH, 32, address width; ADDR_REAL_WIDTH, 20, implemented byte-address bits.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 For each requester i in {0,1} (0 = CPU data port, 1 = loader/debug) the block SHALL have ports: ri_req input 1 request; ri_addr input ADDR_WIDTH byte address; ri_mode input 3 AddrMode; ri_wdata input DATA_WIDTH store data; ri_lock input 1 hold grant; ri_gnt output 1 request accepted; ri_rvalid output 1 response valid; ri_rdata output DATA_WIDTH load data; ri_err output 1 access rejected.
REQ-005 The block SHALL have memory ports: mem_addr output ADDR_WIDTH; mem_mode output 3; mem_wd output DATA_WIDTH; mem_rd input DATA_WIDTH, combinational read data.
REQ-006 AddrMode encoding SHALL be: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.

Function
REQ-007 Arbitration SHALL be combinational each cycle: ri_gnt is high in the cycle the request is accepted; ri_addr/mode/wdata SHALL be captured on that rising edge.
REQ-008 At most one ri_gnt SHALL be high per cycle; a requester SHALL hold ri_req and its fields stable until ri_gnt.
REQ-009 Priority SHALL be round-robin: on contention the requester not granted most recently wins; after reset requester 0 has priority.
REQ-010 If the last granted requester had ri_lock high at grant, and ri_req is high, it SHALL win regardless of round-robin; lock is released when ri_lock or ri_req is low.
REQ-011 FSM SHALL have states IDLE (no captured access) and ACCESS (captured access driven to memory); IDLE->ACCESS and ACCESS->ACCESS on grant, ACCESS->IDLE without grant.
REQ-012 Grants SHALL be issued in both IDLE and ACCESS, giving throughput of one access per cycle.
REQ-013 In ACCESS, mem_addr/mem_mode/mem_wd SHALL equal the captured fields; a store commits at the edge ending ACCESS.
REQ-014 In IDLE, or for a rejected access, mem_mode SHALL be 010 (LW) and mem_addr/mem_wd 0, so memory is never written.
REQ-015 Load data: mem_rd SHALL be registered at the edge ending ACCESS; owner's ri_rvalid is high for exactly the next cycle with ri_rdata = registered value.
REQ-016 Stores SHALL also produce a one-cycle ri_rvalid acknowledge with ri_rdata = 0.
REQ-017 An access SHALL be rejected when: half mode (001/100/110) and addr[0]=1; word mode (010/111) and addr[1:0]!=00; or addr >= 2**ADDR_REAL_WIDTH, or addr + size - 1 >= 2**ADDR_REAL_WIDTH.
REQ-018 A rejected access SHALL still occupy its ACCESS cycle and produce ri_rvalid with ri_err=1 and ri_rdata=0; ri_err is 0 otherwise.
REQ-019 Latency SHALL be fixed: grant in cycle N, memory access in cycle N+1, ri_rvalid in cycle N+2.
REQ-020 ri_rvalid/ri_rdata/ri_err of the non-owning requester SHALL be 0.

Reset
REQ-021 While rst_n=0: state IDLE, round-robin pointer to requester 0, lock cleared, captured access discarded, all ri_gnt/ri_rvalid/ri_err 0, ri_rdata 0, mem_mode 010, mem_addr/mem_wd 0.
REQ-022 Reset asserted during ACCESS SHALL immediately force mem_mode to 010 so the pending store never commits; no response is issued for discarded accesses.

Verification
REQ-023 Single load: mem holds 0x80 at 0x100; r0 LB 0x100 -> r0_gnt cycle N, r0_rvalid cycle N+2, r0_rdata 0xFFFFFF80, r0_err 0.
REQ-024 Contention: r0 and r1 both request every cycle, no lock -> grants alternate 0,1,0,1; each rvalid two cycles after its grant.
REQ-025 Lock: r1 SW 0x200 with r1_lock=1 for 3 accesses while r0 requests -> r1 granted 3 consecutive cycles, r0 granted the following cycle.
REQ-026 Misaligned/range: r0 LW 0x102 -> r0_err=1, r0_rdata 0, memory unchanged; r0 SB 0x100000 -> r0_err=1, no write.
REQ-027 Store then load: r0 SH 0xBEEF to 0x10, then LHU 0x10 back-to-back -> read returns 0x0000BEEF.
REQ-028 Reset during ACCESS of SW 0xDEADBEEF to 0x40 -> location 0x40 unchanged, no rvalid, next grant goes to requester 0.
